// File: rtl/flp_pkg.sv
// Shared types and constants for the link-pulse burst transmitter.
package flp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } flp_state_e;

    localparam logic MODE_NLP = 1'b0;
    localparam logic MODE_FLP = 1'b1;

    function automatic int flp_slots(input int word_w);
        return 2 * word_w + 1;
    endfunction

endpackage

// File: rtl/flp_period_timer.sv
// Burst period counter with a slot phase counter; flags terminal count,
// last cycle of a slot and last cycle of a pulse.
module flp_period_timer #(
    parameter int SLOT_CYC  = 1250,
    parameter int BURST_CYC = 320000,
    parameter int PULSE_CYC = 2,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tc,
    output logic slot_end,
    output logic pulse_end
);

    localparam int PH_W = $clog2(SLOT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;

    // next counter values: clear wins over run
    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
            ph_d  = {PH_W{1'b0}};
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ph_q == PH_W'(SLOT_CYC - 1)) begin
                ph_d = {PH_W{1'b0}};
            end else begin
                ph_d = ph_q + PH_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
            ph_d  = ph_q;
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
            ph_q  <= {PH_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

    assign tc        = (cnt_q == CNT_W'(BURST_CYC - 1));
    assign slot_end  = (ph_q == PH_W'(SLOT_CYC - 1));
    assign pulse_end = (ph_q == PH_W'(PULSE_CYC - 1));

endmodule

// File: rtl/flp_burst_tx.sv
// 10BASE-T link pulse transmitter: FLP bursts or single NLPs on a fixed
// period, with a one-deep pending page buffer loaded at burst start.
module flp_burst_tx
    import flp_pkg::*;
#(
    parameter int PULSE_CYC = 2,
    parameter int SLOT_CYC  = 1250,
    parameter int BURST_CYC = 320000,
    parameter int WORD_W    = 16,
    parameter int CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [WORD_W-1:0] page_data,
    input  logic              page_valid,
    output logic              page_ready,
    output logic              tx_p,
    output logic              tx_active,
    output logic              burst_start,
    output logic              burst_done,
    output logic [7:0]        burst_cnt
);

    localparam int SLOTS  = flp_slots(WORD_W);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int IDX_W  = $clog2(WORD_W);

    flp_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_nxt_s;
    logic [IDX_W-1:0]  data_idx_s;
    logic              mode_q, mode_d;
    logic [WORD_W-1:0] active_q, active_d, pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              arm_q, arm_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              tx_p_q, tx_p_d, tx_active_q, tx_active_d;
    logic              burst_start_q, burst_start_d, burst_done_q, burst_done_d;
    logic              start_s, done_s, to_idle_s, last_s, accept_s, slot_pulse_s;
    logic              clr_s, run_s, tc_s, slot_end_s, pulse_end_s;

    assign page_ready   = !pend_full_q && !burst_start_q;
    assign accept_s     = page_valid && page_ready;
    assign slot_nxt_s   = slot_q + SLOT_W'(1);
    assign data_idx_s   = IDX_W'(slot_nxt_s >> 1);
    // even slots carry clock pulses, odd slots carry data bits LSB first
    assign slot_pulse_s = !slot_nxt_s[0] || active_q[data_idx_s];
    assign last_s       = (mode_q == MODE_NLP) ? (slot_q == {SLOT_W{1'b0}})
                                               : (slot_q == SLOT_W'(SLOTS - 1));
    assign clr_s        = (state_q == ST_IDLE) || start_s || to_idle_s;
    assign run_s        = !clr_s;

    flp_period_timer #(
        .SLOT_CYC  (SLOT_CYC),
        .BURST_CYC (BURST_CYC),
        .PULSE_CYC (PULSE_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .run       (run_s),
        .tc        (tc_s),
        .slot_end  (slot_end_s),
        .pulse_end (pulse_end_s)
    );

    // next-state, page buffer and output decode
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        mode_d      = mode_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        burst_cnt_d = burst_cnt_q;
        arm_d       = 1'b0;
        start_s     = 1'b0;
        done_s      = 1'b0;
        to_idle_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // en is registered once so the burst begins one edge later
                if (arm_q) begin
                    start_s = 1'b1;
                end else begin
                    arm_d = en;
                end
            end
            ST_PULSE: begin
                if (pulse_end_s) begin
                    if (last_s) begin
                        state_d = ST_WAIT;
                        done_s  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_GAP: begin
                if (slot_end_s) begin
                    slot_d  = slot_nxt_s;
                    state_d = slot_pulse_s ? ST_PULSE : ST_GAP;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_WAIT: begin
                if (tc_s) begin
                    if (en) begin
                        start_s = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        to_idle_s = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            state_d = ST_PULSE;
            slot_d  = {SLOT_W{1'b0}};
            mode_d  = mode;
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
            end else begin
                active_d = active_q;
            end
        end else begin
            mode_d = mode_q;
        end

        if (done_s) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end

        if (accept_s) begin
            pend_d      = page_data;
            pend_full_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        tx_p_d        = (state_d == ST_PULSE);
        tx_active_d   = (state_d == ST_PULSE) || (state_d == ST_GAP);
        burst_start_d = start_s;
        burst_done_d  = done_s;
    end

    // state, page buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            slot_q        <= {SLOT_W{1'b0}};
            mode_q        <= MODE_NLP;
            active_q      <= {WORD_W{1'b0}};
            pend_q        <= {WORD_W{1'b0}};
            pend_full_q   <= 1'b0;
            arm_q         <= 1'b0;
            burst_cnt_q   <= 8'd0;
            tx_p_q        <= 1'b0;
            tx_active_q   <= 1'b0;
            burst_start_q <= 1'b0;
            burst_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            mode_q        <= mode_d;
            active_q      <= active_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            arm_q         <= arm_d;
            burst_cnt_q   <= burst_cnt_d;
            tx_p_q        <= tx_p_d;
            tx_active_q   <= tx_active_d;
            burst_start_q <= burst_start_d;
            burst_done_q  <= burst_done_d;
        end
    end

    assign tx_p        = tx_p_q;
    assign tx_active   = tx_active_q;
    assign burst_start = burst_start_q;
    assign burst_done  = burst_done_q;
    assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_flp_burst_tx.sv
// Scoreboard bench for flp_burst_tx: expected burst patterns are queued as
// stimulus is driven and compared by a monitor at each burst_done.
module tb_flp_burst_tx;

    localparam int PULSE_CYC = 2;
    localparam int SLOT_CYC  = 10;
    localparam int BURST_CYC = 400;
    localparam int WORD_W    = 16;
    localparam int CNT_W     = 9;
    localparam int NSLOT     = 2 * WORD_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              mode = 1'b1;
    logic [WORD_W-1:0] page_data = 16'h0000;
    logic              page_valid = 1'b0;
    logic              page_ready, tx_p, tx_active, burst_start, burst_done;
    logic [7:0]        burst_cnt;

    typedef struct {
        logic [NSLOT-1:0] mask;
        int               done_off;
        logic [7:0]       cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_cnt = 0;
    bit   chk_gap = 1'b1;

    // monitor state
    bit               m_in_b = 1'b0;
    bit               m_prev_v = 1'b0;
    int               m_off, m_cyc, m_last_st, m_hi, m_act;
    logic [NSLOT-1:0] m_mask;
    exp_t             m_e;

    flp_burst_tx #(
        .PULSE_CYC (PULSE_CYC),
        .SLOT_CYC  (SLOT_CYC),
        .BURST_CYC (BURST_CYC),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .page_data   (page_data),
        .page_valid  (page_valid),
        .page_ready  (page_ready),
        .tx_p        (tx_p),
        .tx_active   (tx_active),
        .burst_start (burst_start),
        .burst_done  (burst_done),
        .burst_cnt   (burst_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NSLOT-1:0] model_mask(input logic [15:0] pg, input logic flp);
        logic [NSLOT-1:0] m;
        m = '0;
        if (!flp) begin
            m[0] = 1'b1;
        end else begin
            for (int k = 0; k < NSLOT; k++) m[k] = (k % 2 == 0) ? 1'b1 : pg[k / 2];
        end
        return m;
    endfunction

    task automatic push_exp(input logic [15:0] pg, input logic flp);
        exp_t e;
        model_cnt++;
        e.mask     = model_mask(pg, flp);
        e.done_off = flp ? 322 : 2;
        e.cnt      = 8'(model_cnt);
        sb_q.push_back(e);
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (burst_start) seen = 1'b1;
        end
        if (!seen) chk_eq("start_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (burst_done) seen = 1'b1;
        end
        if (!seen) chk_eq("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic offer(input logic [15:0] pg);
        bit ok = 1'b0;
        page_data  = pg;
        page_valid = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (page_ready) ok = 1'b1;
            @(negedge clk);
        end
        page_valid = 1'b0;
        if (!ok) chk_eq("offer_timeout", 64'd0, 64'd1);
        else chk_eq("ready_fall", page_ready, 1'b0);
    endtask

    task automatic raise_en();
        en = 1'b1;
        @(negedge clk);
        chk_eq("start_lat_early", burst_start, 1'b0);
        @(negedge clk);
        chk_eq("start_lat", burst_start, 1'b1);
    endtask

    // monitor: rebuilds each burst's pulse pattern and checks it at burst_done
    initial forever begin
        @(negedge clk);
        m_cyc++;
        if (!rst_n) begin
            m_in_b   = 1'b0;
            m_prev_v = 1'b0;
        end else begin
            if (burst_start) begin
                if (m_prev_v && chk_gap) chk_eq("period", m_cyc - m_last_st, BURST_CYC);
                m_prev_v  = 1'b1;
                m_last_st = m_cyc;
                m_in_b    = 1'b1;
                m_off     = 0;
                m_mask    = '0;
                m_hi      = 0;
                m_act     = 0;
            end
            if (m_in_b) begin
                if (tx_p) m_hi++;
                if (tx_active) m_act++;
                if (tx_p && (m_off % SLOT_CYC == 0) && (m_off / SLOT_CYC < NSLOT))
                    m_mask[m_off / SLOT_CYC] = 1'b1;
                if (burst_done) begin
                    if (sb_q.size() == 0) begin
                        chk_eq("sb_empty", 64'd0, 64'd1);
                    end else begin
                        m_e = sb_q.pop_front();
                        chk_eq("pulse_mask", m_mask, m_e.mask);
                        chk_eq("pulse_cycles", m_hi, $countones(m_e.mask) * PULSE_CYC);
                        chk_eq("done_off", m_off, m_e.done_off);
                        chk_eq("active_cycles", m_act, m_e.done_off);
                        chk_eq("burst_cnt", burst_cnt, m_e.cnt);
                    end
                    m_in_b = 1'b0;
                end
                m_off++;
            end else begin
                chk_eq("idle_txp", tx_p, 1'b0);
                chk_eq("idle_done", burst_done, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int starts;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_txp", tx_p, 1'b0);
        chk_eq("rst_active", tx_active, 1'b0);
        chk_eq("rst_ready", page_ready, 1'b1);
        chk_eq("rst_cnt", burst_cnt, 8'd0);

        // FLP with a single data bit set, then all ones, then all zeros
        offer(16'h0001);
        push_exp(16'h0001, 1'b1);
        raise_en();
        offer(16'hFFFF);
        push_exp(16'hFFFF, 1'b1);
        wait_start();
        offer(16'h0000);
        push_exp(16'h0000, 1'b1);
        wait_start();

        // NLP: mode change is only seen at the next burst start
        mode = 1'b0;
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0000, 1'b0);
        wait_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            page_data = 16'($urandom);
        end
        wait_start();

        // handshake: 0x1234 pends, 0x5678 waits for the buffer to drain
        offer(16'h1234);
        mode       = 1'b1;
        page_data  = 16'h5678;
        page_valid = 1'b1;
        push_exp(16'h1234, 1'b1);
        wait_start();
        chk_eq("ready_in_start", page_ready, 1'b0);
        @(negedge clk);
        chk_eq("ready_after_start", page_ready, 1'b1);
        @(negedge clk);
        chk_eq("ready_after_accept", page_ready, 1'b0);
        page_valid = 1'b0;
        push_exp(16'h5678, 1'b1);
        wait_start();
        push_exp(16'h5678, 1'b1);
        wait_start();

        // drop en mid-burst: burst completes, no restart
        repeat (100) @(negedge clk);
        en = 1'b0;
        wait_done();
        starts = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (burst_start) starts++;
        end
        chk_eq("no_restart", starts, 0);
        chk_eq("idle_active", tx_active, 1'b0);
        chk_gap = 1'b0;

        // reset during the data pulse at offset 10
        offer(16'h0003);
        raise_en();
        repeat (10) @(negedge clk);
        chk_eq("pulse_at_10", tx_p, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_async_txp", tx_p, 1'b0);
        chk_eq("rst_async_active", tx_active, 1'b0);
        en = 1'b0;
        model_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("post_rst_ready", page_ready, 1'b1);
        chk_eq("post_rst_cnt", burst_cnt, 8'd0);
        mode = 1'b1;
        push_exp(16'h0000, 1'b1);
        raise_en();
        wait_done();
        repeat (5) @(negedge clk);
        chk_eq("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flp_burst_tx.md
Name: flp_burst_tx

Overview:
Parametrised 10BASE-T link-pulse transmitter: emits Fast Link Pulse bursts (17 clock + 16 data pulse positions) carrying a 16-bit link code word, or single Normal Link Pulses, repeated on a fixed period. It adds a page handshake (one-deep pending buffer for base/next pages), run-time NLP/FLP mode select, and an enable with clean burst completion. It drives the TP transmit pulse path ahead of the line driver in the Ethernet PHY front end.

Parameters:
PULSE_CYC, 2, tx_p high time in clk cycles (100 ns at 20 MHz)
SLOT_CYC, 1250, spacing between consecutive pulse positions (62.5 us)
BURST_CYC, 320000, burst-start to burst-start period (16 ms)
WORD_W, 16, link code word width; FLP has 2*WORD_W+1 slots
CNT_W, 20, period counter width; must hold BURST_CYC-1
Legal only if PULSE_CYC < SLOT_CYC and 2*WORD_W*SLOT_CYC + PULSE_CYC < BURST_CYC.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  enable burst generation
mode  in  1  0 = NLP, 1 = FLP; sampled only at burst start
page_data  in  WORD_W  link code word offered
page_valid  in  1  page_data valid
page_ready  out  1  pending buffer can accept
tx_p  out  1  link pulse output (registered)
tx_active  out  1  high from first to last pulse cycle of a burst
burst_start  out  1  1-cycle strobe, coincides with first tx_p high cycle
burst_done  out  1  1-cycle strobe, cycle after last tx_p high cycle
burst_cnt  out  8  completed bursts, wraps 255->0

Behaviour:
- Reset (async): tx_p, tx_active, burst_start, burst_done = 0; burst_cnt = 0; active page = 0; pending empty; state IDLE; page_ready = 1 once pending is empty.
- States: IDLE, PULSE (tx_p high), GAP (between slots), WAIT (burst done, period running).
- IDLE: if en sampled high at edge N, burst begins at edge N+1 (burst_start=1, tx_p=1). Period counter is 0 in the burst_start cycle and increments every cycle.
- Burst start: mode latched; if pending full, pending -> active page and pending cleared; page_ready forced 0 in the burst_start cycle.
- FLP: slot k (k = 0..2*WORD_W) starts at offset k*SLOT_CYC. Even k: clock pulse, always emitted. Odd k = 2i+1: data bit i of active page, LSB first; pulse only if bit = 1. Every pulse is exactly PULSE_CYC cycles high.
- NLP: single pulse at offset 0 only; data is ignored.
- burst_done is asserted at offset last_pulse_offset + PULSE_CYC. In the same cycle burst_cnt increments and tx_active falls. State then goes to WAIT.
- WAIT: at counter = BURST_CYC-1, if en = 1, the next burst_start follows (exact period BURST_CYC). If en = 0, go to IDLE and clear the counter.
- en deasserted mid-burst: the burst completes unchanged. The decision is taken only at the WAIT end.
- Handshake: transfer when page_valid && page_ready. page_ready = !pending_full && !burst_start. A page accepted mid-burst does not affect the current burst. With no new page, the active page repeats every burst.
- mode change mid-burst: ignored until the next burst start.
- Reset mid-pulse: tx_p low immediately; pending and active cleared.

Decomposition:
- flp_pkg: state enum; MODE_NLP/MODE_FLP constants; function flp_slots(WORD_W) = 2*WORD_W+1.
- One sub-module, flp_period_timer: CNT_W counter with clear/run, terminal-count flag at BURST_CYC-1, and slot-boundary flag every SLOT_CYC within the burst.

Test Plan (PULSE_CYC=2, SLOT_CYC=10, BURST_CYC=400, WORD_W=16):
1. FLP, page 0x0001 -> clock pulses at offsets 0,20,...,320 plus a data pulse at 10 only (18 pulses, each 2 cycles high); burst_done at offset 322; next burst_start at offset 400.
2. FLP, page 0xFFFF -> 33 pulses at offsets 0,10,...,320; page 0x0000 -> 17 clock pulses only; burst_cnt increments once per burst.
3. NLP mode -> one 2-cycle pulse per 400 cycles; burst_done at offset 2; page_data changes have no effect on tx_p.
4. Handshake: offer 0x1234 (accepted, ready -> 0), then hold 0x5678 valid. At next burst_start, 0x1234 is sent and ready rises the following cycle. 0x5678 is accepted and sent in the burst after that.
5. Drop en at offset 100 -> burst completes to burst_done at 322, no burst_start at 400, state IDLE. Raise en at edge N -> burst_start at N+1.
6. Assert rst_n=0 during a pulse at offset 10 -> tx_p 0 asynchronously. After release: page_ready=1, burst_cnt=0, and the first FLP burst carries page 0x0000.
